// File: rtl/mandelbrot_sequencer.sv
// mandelbrot_sequencer: frame-level controller issuing per-pixel engine runs into a result FIFO stream
module mandelbrot_sequencer #(
  parameter int BITWIDTH   = 10,
  parameter int CTRWIDTH   = 7,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_cnt,
  output logic                seq_error,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [BITWIDTH-1:0] cfg_wdata,
  output logic                core_run,
  input  logic                core_running,
  input  logic                core_finished,
  input  logic [3:0]          core_ctr,
  output logic [CTRWIDTH-1:0] core_max_ctr,
  output logic [2:0]          core_ctr_select,
  output logic [6:0]          core_scaling,
  output logic [BITWIDTH-1:0] core_cr_offset,
  output logic [BITWIDTH-1:0] core_ci_offset,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [3:0]          pix_data,
  output logic                pix_last
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW = $clog2(NPIX + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, FRAME_END} state_t;
  state_t state;
  logic [CTRWIDTH-1:0] max_s;
  logic [2:0] sel_s;
  logic [6:0] scl_s;
  logic [BITWIDTH-1:0] cro_s, cio_s, crs_s, cis_s, crs_a, cis_a;
  logic zen_s, zen_a;
  logic [PW-1:0] pix_cnt;
  logic [4:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic push, pop, last;
  always_comb begin
    last = pix_cnt == PW'(NPIX - 1);
    push = state == WAIT_LO && !core_running;
    pop = pix_valid && pix_ready;
    core_run = state == ISSUE && cnt < (AW+1)'(FIFO_DEPTH) && !core_running;
    busy = state != IDLE;
    frame_done = state == FRAME_END;
    pix_valid = cnt != '0;
    {pix_data, pix_last} = pix_valid ? mem[rd_ptr] : 5'd0;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {core_ctr, last};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frame_cnt <= '0;
      seq_error <= 1'b0;
      pix_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      max_s <= '1;
      sel_s <= '0;
      scl_s <= 7'd1;
      cro_s <= '0;
      cio_s <= '0;
      zen_s <= 1'b0;
      crs_s <= '0;
      cis_s <= '0;
      core_max_ctr <= '1;
      core_ctr_select <= '0;
      core_scaling <= 7'd1;
      core_cr_offset <= '0;
      core_ci_offset <= '0;
      zen_a <= 1'b0;
      crs_a <= '0;
      cis_a <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (core_finished) state <= LOAD;
          else seq_error <= 1'b1;
        end
        LOAD: begin
          core_max_ctr <= max_s;
          core_ctr_select <= sel_s;
          core_scaling <= scl_s;
          core_cr_offset <= cro_s;
          core_ci_offset <= cio_s;
          zen_a <= zen_s;
          crs_a <= crs_s;
          cis_a <= cis_s;
          pix_cnt <= '0;
          state <= ISSUE;
        end
        ISSUE: if (core_run) state <= WAIT_HI;
        WAIT_HI: if (core_running) state <= WAIT_LO;
        WAIT_LO: if (push) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (core_finished != last) seq_error <= 1'b1;
          state <= last ? FRAME_END : ISSUE;
        end
        FRAME_END: begin
          frame_cnt <= frame_cnt + 8'd1;
          if (zen_a) begin
            scl_s <= scl_s == 7'd0 ? 7'd0 : scl_s - 7'd1;
            cro_s <= cro_s + crs_a;
            cio_s <= cio_s + cis_a;
          end
          state <= continuous ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      // host writes come last so they override the auto-zoom update of the same field
      if (cfg_we)
        case (cfg_addr)
          3'd0: max_s <= cfg_wdata[CTRWIDTH-1:0];
          3'd1: sel_s <= cfg_wdata[2:0];
          3'd2: scl_s <= cfg_wdata[6:0];
          3'd3: cro_s <= cfg_wdata;
          3'd4: cio_s <= cfg_wdata;
          3'd5: zen_s <= cfg_wdata[0];
          3'd6: crs_s <= cfg_wdata;
          default: cis_s <= cfg_wdata;
        endcase
    end
  end
endmodule

// File: tb/tb_mandelbrot_sequencer.sv
// tb_mandelbrot_sequencer: randomized engine/sink model with a frame-level config and pixel scoreboard
module tb_mandelbrot_sequencer;
  localparam int BW = 10, CW = 7, W = 4, H = 2, FD = 4, NPIX = W * H;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, continuous = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [BW-1:0] cfg_wdata = '0;
  logic core_run, core_running = 1'b0, eng_fin = 1'b1, fin_block = 1'b0, core_finished;
  logic [3:0] core_ctr = '0;
  logic busy, frame_done, seq_error, pix_valid, pix_last, pix_ready = 1'b0;
  logic [7:0] frame_cnt;
  logic [CW-1:0] core_max_ctr;
  logic [2:0] core_ctr_select;
  logic [6:0] core_scaling;
  logic [BW-1:0] core_cr_offset, core_ci_offset;
  logic [3:0] pix_data;
  logic [4:0] e;
  int n_tests = 0, n_fail = 0;
  int runs = 0, recv = 0, dones = 0, nlast = 0, epix = 0, err_idx = -1, ctr_fix = -1;
  bit rdy_rnd = 0, rdy_val = 1, first_run = 0;
  int sh[8], act[8];
  int fmask[8] = '{127, 7, 127, 1023, 1023, 1, 1023, 1023};
  logic [4:0] exp_q[$];
  int scl_q[$], cr_q[$];
  assign core_finished = eng_fin & ~fin_block;
  always #5 clk = ~clk;
  mandelbrot_sequencer #(.BITWIDTH(BW), .CTRWIDTH(CW), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .seq_error(seq_error),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .core_run(core_run), .core_running(core_running), .core_finished(core_finished),
    .core_ctr(core_ctr), .core_max_ctr(core_max_ctr), .core_ctr_select(core_ctr_select),
    .core_scaling(core_scaling), .core_cr_offset(core_cr_offset), .core_ci_offset(core_ci_offset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_cfg();
    chk("cfg_max_ctr", 32'(core_max_ctr), act[0]);
    chk("cfg_ctr_select", 32'(core_ctr_select), act[1]);
    chk("cfg_scaling", 32'(core_scaling), act[2]);
    chk("cfg_cr_offset", 32'(core_cr_offset), act[3]);
    chk("cfg_ci_offset", 32'(core_ci_offset), act[4]);
  endtask
  // engine model: run -> running high after a random delay for a random time -> result
  initial forever begin
    @(negedge clk);
    if (core_run) begin
      int idx;
      logic [3:0] c;
      idx = epix;
      epix++;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      core_running = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      c = ctr_fix >= 0 ? 4'(ctr_fix) : 4'($urandom_range(0, 15));
      core_running = 1'b0;
      core_ctr = c;
      eng_fin = idx == NPIX - 1 || idx == err_idx;
      exp_q.push_back({c, idx == NPIX - 1});
    end
  end
  initial forever begin
    @(posedge clk);
    #1 pix_ready = rdy_rnd ? 1'($urandom_range(0, 1)) : rdy_val;
  end
  // sink, run counter and frame-level config model
  always @(negedge clk) begin
    if (core_run) begin
      runs++;
      if (first_run) begin
        act = sh;
        chk_cfg();
        scl_q.push_back(int'(core_scaling));
        cr_q.push_back(int'(core_cr_offset));
        first_run = 0;
      end
    end
    if (pix_valid && pix_ready) begin
      recv++;
      if (pix_last) nlast++;
      if (exp_q.size() == 0) chk("pix_extra", 32'(pix_data), 32'hFFFF);
      else begin
        e = exp_q.pop_front();
        chk("pix_data", 32'(pix_data), 32'(e[4:1]));
        chk("pix_last", 32'(pix_last), 32'(e[0]));
      end
    end
    if (frame_done) begin
      dones++;
      chk_cfg();
      if (act[5] != 0) begin
        sh[2] = sh[2] == 0 ? 0 : sh[2] - 1;
        sh[3] = (sh[3] + act[6]) % 1024;
        sh[4] = (sh[4] + act[7]) % 1024;
      end
      first_run = 1;
      epix = 0;
    end
  end
  task automatic cfg_wr(int a, int d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_wdata = BW'(d);
    sh[a] = d & fmask[a];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  task automatic start_frame();
    @(negedge clk);
    epix = 0;
    first_run = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_frames(int t);
    int k = 0;
    while (dones < t && k < 3000) begin
      @(negedge clk);
      #1 k++;
    end
    chk("frame_timeout", 32'(dones >= t), 1);
  endtask
  task automatic wait_runs(int n, bit need_running);
    int k = 0;
    while (!(runs >= n && (!need_running || core_running)) && k < 2000) begin
      @(negedge clk);
      #1 k++;
    end
    chk("run_timeout", 32'(k < 2000), 1);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      #1 k++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask
  initial begin
    sh = '{127, 0, 1, 0, 0, 0, 0, 0};
    act = sh;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_core_run", 32'(core_run), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_last", 32'(pix_last), 0);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_seq_error", 32'(seq_error), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk_cfg();
    rst = 1'b0;
    ctr_fix = 3;
    start_frame();
    wait_frames(1);
    repeat (2) @(negedge clk);
    chk("f1_frame_cnt", 32'(frame_cnt), 1);
    chk("f1_seq_error", 32'(seq_error), 0);
    chk("f1_runs", 32'(runs), 8);
    chk("f1_recv", 32'(recv), 8);
    chk("f1_nlast", 32'(nlast), 1);
    chk("f1_dones", 32'(dones), 1);
    ctr_fix = -1;
    runs = 0;
    recv = 0;
    rdy_val = 0;
    start_frame();
    repeat (150) @(negedge clk);
    #1 chk("bp_runs_stall", 32'(runs), 4);
    chk("bp_recv_stall", 32'(recv), 0);
    chk("bp_valid_stall", 32'(pix_valid), 1);
    rdy_val = 1;
    wait_frames(2);
    repeat (3) @(negedge clk);
    chk("bp_recv", 32'(recv), 8);
    chk("bp_runs", 32'(runs), 8);
    chk("bp_q_empty", 32'(exp_q.size()), 0);
    rdy_rnd = 1;
    runs = 0;
    cr_q.delete();
    start_frame();
    wait_runs(1, 0);
    cfg_wr(3, 'h010);
    chk("cr_hold", 32'(core_cr_offset), 0);
    wait_frames(3);
    start_frame();
    wait_frames(4);
    chk("cr_before", 32'(cr_q[0]), 0);
    chk("cr_after", 32'(cr_q[1]), 'h010);
    cfg_wr(5, 1);
    cfg_wr(2, 1);
    cfg_wr(6, 'h3FF);
    cfg_wr(3, 0);
    scl_q.delete();
    cr_q.delete();
    continuous = 1'b1;
    start_frame();
    wait_frames(6);
    @(negedge clk);
    continuous = 1'b0;
    wait_frames(7);
    wait_idle();
    chk("zoom_frames", 32'(scl_q.size()), 3);
    chk("zoom_scl0", 32'(scl_q[0]), 1);
    chk("zoom_scl1", 32'(scl_q[1]), 0);
    chk("zoom_scl2", 32'(scl_q[2]), 0);
    chk("zoom_cr0", 32'(cr_q[0]), 'h000);
    chk("zoom_cr1", 32'(cr_q[1]), 'h3FF);
    chk("zoom_cr2", 32'(cr_q[2]), 'h3FE);
    chk("zoom_frame_cnt", 32'(frame_cnt), 7);
    cfg_wr(5, 0);
    err_idx = 4;
    start_frame();
    wait_frames(8);
    err_idx = -1;
    repeat (10) @(negedge clk);
    chk("err_sticky", 32'(seq_error), 1);
    chk("err_frame_cnt", 32'(frame_cnt), 8);
    chk("err_idle", 32'(busy), 0);
    rdy_rnd = 0;
    rdy_val = 1;
    repeat (10) @(negedge clk);
    rdy_val = 0;
    runs = 0;
    start_frame();
    wait_runs(3, 1);
    chk("pre_rst_valid", 32'(pix_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(pix_valid), 0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("mid_rst_core_run", 32'(core_run), 0);
    chk("mid_rst_seq_error", 32'(seq_error), 0);
    chk("mid_rst_scaling", 32'(core_scaling), 1);
    chk("mid_rst_cr", 32'(core_cr_offset), 0);
    rst = 1'b0;
    sh = '{127, 0, 1, 0, 0, 0, 0, 0};
    rdy_val = 1;
    repeat (30) @(negedge clk);
    chk("post_rst_runs", 32'(runs), 3);
    chk("post_rst_valid", 32'(pix_valid), 0);
    exp_q.delete();
    epix = 0;
    runs = 0;
    fin_block = 1'b1;
    start_frame();
    repeat (5) @(negedge clk);
    chk("nofin_seq_error", 32'(seq_error), 1);
    chk("nofin_busy", 32'(busy), 0);
    chk("nofin_runs", 32'(runs), 0);
    fin_block = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
